// File: rtl/vx_cache_pkg.sv
// Shared definitions for the cache bank request scheduler.
// - SRC_* : encodings of the st1 request source (st1_src).
// - sched_state_e : scheduler FSM states.
package vx_cache_pkg;

  localparam logic [1:0] SRC_FILL = 2'd0;
  localparam logic [1:0] SRC_MRVQ = 2'd1;
  localparam logic [1:0] SRC_SNP  = 2'd2;
  localparam logic [1:0] SRC_CORE = 2'd3;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } sched_state_e;

endpackage

// File: rtl/vx_bank_prio_arbiter.sv
// Combinational 4-way fixed-priority arbiter.
// Ports:
//   req     in  4  request per source, indexed by SRC_* encoding
//   promote in  1  lift core to rank directly below fill
//   gnt     out 4  one-hot grant (all zero when nothing requests)
// Normal order: fill > mrvq > snp > core.
// Promoted order: fill > core > mrvq > snp.
module vx_bank_prio_arbiter
  import vx_cache_pkg::*;
(
  input  logic [3:0] req,
  input  logic       promote,
  output logic [3:0] gnt
);

  always_comb begin
    gnt = '0;
    if (req[SRC_FILL]) begin
      gnt[SRC_FILL] = 1'b1;
    end else if (promote && req[SRC_CORE]) begin
      gnt[SRC_CORE] = 1'b1;
    end else if (req[SRC_MRVQ]) begin
      gnt[SRC_MRVQ] = 1'b1;
    end else if (req[SRC_SNP]) begin
      gnt[SRC_SNP] = 1'b1;
    end else if (req[SRC_CORE]) begin
      gnt[SRC_CORE] = 1'b1;
    end
  end

endmodule

// File: rtl/vx_bank_req_sched.sv
// Per-bank input scheduler feeding the tag/data access stage (st1).
// Arbitrates DRAM fill, miss-reserve replay (mrvq), snoop and core requests
// into a single st1 register, and runs a line-invalidate sweep after reset
// and on flush request.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   stall_bank_pipe             hold st1 and counters, no grants
//   fill_*  / fill_ready        DRAM fill request (addr, data)
//   mrvq_*  / mrvq_ready        miss-reserve replay request
//   snp_*   / snp_ready         snoop request (addr, invalidate flag)
//   core_*  / core_ready        core request
//   mrvq_almost_full            blocks core requests
//   snprsp_full                 blocks snoop requests
//   flush_req                   start an invalidate sweep (sampled in RUN)
//   flush_busy                  sweep in progress (INIT/FLUSH)
//   flush_done                  one-cycle pulse after the last sweep op
//   st1_*                       registered st1 request
module vx_bank_req_sched
  import vx_cache_pkg::*;
#(
  parameter int LINE_ADDR_WIDTH = 26,
  parameter int LINE_WIDTH      = 128,
  parameter int WORD_SIZE       = 4,
  parameter int WORD_SEL_WIDTH  = 2,
  parameter int TAG_ID_BITS     = 8,
  parameter int NUM_LINES       = 64,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall_bank_pipe,

  input  logic                       fill_valid,
  output logic                       fill_ready,
  input  logic [LINE_ADDR_WIDTH-1:0] fill_addr,
  input  logic [LINE_WIDTH-1:0]      fill_data,

  input  logic                       mrvq_valid,
  output logic                       mrvq_ready,
  input  logic [LINE_ADDR_WIDTH-1:0] mrvq_addr,
  input  logic [8*WORD_SIZE-1:0]     mrvq_word,
  input  logic                       mrvq_rw,
  input  logic [WORD_SIZE-1:0]       mrvq_byteen,
  input  logic [WORD_SEL_WIDTH-1:0]  mrvq_wsel,
  input  logic [TAG_ID_BITS-1:0]     mrvq_tag,

  input  logic                       snp_valid,
  output logic                       snp_ready,
  input  logic [LINE_ADDR_WIDTH-1:0] snp_addr,
  input  logic                       snp_inv,

  input  logic                       core_valid,
  output logic                       core_ready,
  input  logic [LINE_ADDR_WIDTH-1:0] core_addr,
  input  logic [8*WORD_SIZE-1:0]     core_word,
  input  logic                       core_rw,
  input  logic [WORD_SIZE-1:0]       core_byteen,
  input  logic [WORD_SEL_WIDTH-1:0]  core_wsel,
  input  logic [TAG_ID_BITS-1:0]     core_tag,

  input  logic                       mrvq_almost_full,
  input  logic                       snprsp_full,

  input  logic                       flush_req,
  output logic                       flush_busy,
  output logic                       flush_done,

  output logic                       st1_valid,
  output logic                       st1_writefill,
  output logic                       st1_is_snp,
  output logic                       st1_snp_inv,
  output logic                       st1_rw,
  output logic                       st1_flush,
  output logic [1:0]                 st1_src,
  output logic [LINE_ADDR_WIDTH-1:0] st1_addr,
  output logic [LINE_WIDTH-1:0]      st1_data,
  output logic [8*WORD_SIZE-1:0]     st1_word,
  output logic [WORD_SIZE-1:0]       st1_byteen,
  output logic [WORD_SEL_WIDTH-1:0]  st1_wsel,
  output logic [TAG_ID_BITS-1:0]     st1_tag
);

  localparam int IDX_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  sched_state_e     state;
  logic [IDX_W-1:0] sweep_idx;
  logic [CNT_W-1:0] starve_cnt;

  logic       advance;
  logic       in_run;
  logic       core_elig;
  logic       snp_elig;
  logic       promote;
  logic       sweep_last;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [LINE_ADDR_WIDTH-1:0] sweep_addr;

  assign advance    = ~stall_bank_pipe;
  assign in_run     = (state == S_RUN);
  assign core_elig  = core_valid & ~mrvq_almost_full;
  assign snp_elig   = snp_valid & ~snprsp_full;
  assign promote    = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign sweep_last = (sweep_idx == IDX_W'(NUM_LINES - 1));
  assign sweep_addr = LINE_ADDR_WIDTH'(sweep_idx);
  assign flush_busy = ~in_run;

  always_comb begin
    req           = '0;
    req[SRC_FILL] = fill_valid;
    req[SRC_MRVQ] = mrvq_valid;
    req[SRC_SNP]  = snp_elig;
    req[SRC_CORE] = core_elig;
  end

  vx_bank_prio_arbiter u_arbiter (
    .req     (req),
    .promote (promote),
    .gnt     (gnt)
  );

  // Grants are only visible as readies in RUN on an advancing cycle, so the
  // sweep and a stall never consume a request.
  assign fill_ready = advance & in_run & gnt[SRC_FILL];
  assign mrvq_ready = advance & in_run & gnt[SRC_MRVQ];
  assign snp_ready  = advance & in_run & gnt[SRC_SNP];
  assign core_ready = advance & in_run & gnt[SRC_CORE];

  // FSM, sweep index, starvation counter and st1 register. On an advancing
  // cycle every st1 field is first cleared so that fields a source does not
  // carry read as zero, then the winning op overwrites its own fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_INIT;
      sweep_idx     <= '0;
      starve_cnt    <= '0;
      flush_done    <= 1'b0;
      st1_valid     <= 1'b0;
      st1_writefill <= 1'b0;
      st1_is_snp    <= 1'b0;
      st1_snp_inv   <= 1'b0;
      st1_rw        <= 1'b0;
      st1_flush     <= 1'b0;
      st1_src       <= '0;
      st1_addr      <= '0;
      st1_data      <= '0;
      st1_word      <= '0;
      st1_byteen    <= '0;
      st1_wsel      <= '0;
      st1_tag       <= '0;
    end else begin
      flush_done <= 1'b0;
      if (advance) begin
        st1_valid     <= 1'b0;
        st1_writefill <= 1'b0;
        st1_is_snp    <= 1'b0;
        st1_snp_inv   <= 1'b0;
        st1_rw        <= 1'b0;
        st1_flush     <= 1'b0;
        st1_src       <= '0;
        st1_addr      <= '0;
        st1_data      <= '0;
        st1_word      <= '0;
        st1_byteen    <= '0;
        st1_wsel      <= '0;
        st1_tag       <= '0;

        case (state)
          S_INIT, S_FLUSH: begin
            st1_valid   <= 1'b1;
            st1_is_snp  <= 1'b1;
            st1_snp_inv <= 1'b1;
            st1_flush   <= 1'b1;
            st1_addr    <= sweep_addr;
            if (sweep_last) begin
              state      <= S_RUN;
              sweep_idx  <= '0;
              flush_done <= 1'b1;
            end else begin
              sweep_idx <= sweep_idx + 1'b1;
            end
          end

          S_RUN: begin
            if (gnt[SRC_FILL]) begin
              st1_valid     <= 1'b1;
              st1_src       <= SRC_FILL;
              st1_writefill <= 1'b1;
              st1_addr      <= fill_addr;
              st1_data      <= fill_data;
            end else if (gnt[SRC_MRVQ]) begin
              st1_valid  <= 1'b1;
              st1_src    <= SRC_MRVQ;
              st1_addr   <= mrvq_addr;
              st1_word   <= mrvq_word;
              st1_rw     <= mrvq_rw;
              st1_byteen <= mrvq_byteen;
              st1_wsel   <= mrvq_wsel;
              st1_tag    <= mrvq_tag;
            end else if (gnt[SRC_SNP]) begin
              st1_valid   <= 1'b1;
              st1_src     <= SRC_SNP;
              st1_is_snp  <= 1'b1;
              st1_snp_inv <= snp_inv;
              st1_addr    <= snp_addr;
            end else if (gnt[SRC_CORE]) begin
              st1_valid  <= 1'b1;
              st1_src    <= SRC_CORE;
              st1_addr   <= core_addr;
              st1_word   <= core_word;
              st1_rw     <= core_rw;
              st1_byteen <= core_byteen;
              st1_wsel   <= core_wsel;
              st1_tag    <= core_tag;
            end

            // Starvation only counts cycles where core could have gone but
            // lost; a core blocked by mrvq_almost_full keeps its count.
            if (!core_valid || gnt[SRC_CORE]) begin
              starve_cnt <= '0;
            end else if (core_elig && !promote) begin
              starve_cnt <= starve_cnt + 1'b1;
            end

            if (flush_req) begin
              state <= S_FLUSH;
            end
          end

          default: begin
            state     <= S_INIT;
            sweep_idx <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vx_bank_req_sched.sv
// Self-checking bench for vx_bank_req_sched: reset sweep, single-cycle
// arbitration vectors from a table, and hand-written multi-cycle sequences
// for ordering, starvation, stall, flush and reset-during-sweep.
module tb_vx_bank_req_sched;
  import vx_cache_pkg::*;

  localparam int LAW = 26;
  localparam int LW  = 128;
  localparam int WS  = 4;
  localparam int WSW = 2;
  localparam int TB  = 8;
  localparam int NL  = 64;
  localparam int SL  = 8;

  localparam logic [LAW-1:0] FILL_ADDR = 26'h0000111;
  localparam logic [LW-1:0]  FILL_DATA = 128'hF00D_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [LAW-1:0] MRVQ_ADDR = 26'h0000222;
  localparam logic [31:0]    MRVQ_WORD = 32'hAAAA_0001;
  localparam logic [3:0]     MRVQ_BEN  = 4'hF;
  localparam logic [1:0]     MRVQ_WSEL = 2'd1;
  localparam logic [7:0]     MRVQ_TAG  = 8'h21;
  localparam logic [LAW-1:0] SNP_ADDR  = 26'h0000333;
  localparam logic [LAW-1:0] CORE_ADDR = 26'h0000444;
  localparam logic [31:0]    CORE_WORD = 32'hCCCC_0003;
  localparam logic [3:0]     CORE_BEN  = 4'h3;
  localparam logic [1:0]     CORE_WSEL = 2'd2;
  localparam logic [7:0]     CORE_TAG  = 8'h43;

  logic clk = 1'b0;
  logic reset;
  logic stall_bank_pipe;
  logic fill_valid, fill_ready;
  logic mrvq_valid, mrvq_ready;
  logic snp_valid, snp_ready;
  logic core_valid, core_ready;
  logic mrvq_almost_full, snprsp_full, flush_req;
  logic flush_busy, flush_done;
  logic st1_valid, st1_writefill, st1_is_snp, st1_snp_inv, st1_rw, st1_flush;
  logic [1:0]     st1_src;
  logic [LAW-1:0] st1_addr;
  logic [LW-1:0]  st1_data;
  logic [31:0]    st1_word;
  logic [3:0]     st1_byteen;
  logic [1:0]     st1_wsel;
  logic [7:0]     st1_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vx_bank_req_sched #(
    .LINE_ADDR_WIDTH (LAW),
    .LINE_WIDTH      (LW),
    .WORD_SIZE       (WS),
    .WORD_SEL_WIDTH  (WSW),
    .TAG_ID_BITS     (TB),
    .NUM_LINES       (NL),
    .STARVE_LIMIT    (SL)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .stall_bank_pipe  (stall_bank_pipe),
    .fill_valid       (fill_valid),
    .fill_ready       (fill_ready),
    .fill_addr        (FILL_ADDR),
    .fill_data        (FILL_DATA),
    .mrvq_valid       (mrvq_valid),
    .mrvq_ready       (mrvq_ready),
    .mrvq_addr        (MRVQ_ADDR),
    .mrvq_word        (MRVQ_WORD),
    .mrvq_rw          (1'b1),
    .mrvq_byteen      (MRVQ_BEN),
    .mrvq_wsel        (MRVQ_WSEL),
    .mrvq_tag         (MRVQ_TAG),
    .snp_valid        (snp_valid),
    .snp_ready        (snp_ready),
    .snp_addr         (SNP_ADDR),
    .snp_inv          (1'b0),
    .core_valid       (core_valid),
    .core_ready       (core_ready),
    .core_addr        (CORE_ADDR),
    .core_word        (CORE_WORD),
    .core_rw          (1'b0),
    .core_byteen      (CORE_BEN),
    .core_wsel        (CORE_WSEL),
    .core_tag         (CORE_TAG),
    .mrvq_almost_full (mrvq_almost_full),
    .snprsp_full      (snprsp_full),
    .flush_req        (flush_req),
    .flush_busy       (flush_busy),
    .flush_done       (flush_done),
    .st1_valid        (st1_valid),
    .st1_writefill    (st1_writefill),
    .st1_is_snp       (st1_is_snp),
    .st1_snp_inv      (st1_snp_inv),
    .st1_rw           (st1_rw),
    .st1_flush        (st1_flush),
    .st1_src          (st1_src),
    .st1_addr         (st1_addr),
    .st1_data         (st1_data),
    .st1_word         (st1_word),
    .st1_byteen       (st1_byteen),
    .st1_wsel         (st1_wsel),
    .st1_tag          (st1_tag)
  );

  logic [3:0] rdy;
  assign rdy = {core_ready, snp_ready, mrvq_ready, fill_ready};

  typedef struct {
    logic [3:0] valids;   // {core, snp, mrvq, fill}
    logic       af;
    logic       sf;
    logic [3:0] exp_rdy;  // {core, snp, mrvq, fill}
    logic       exp_vld;
    logic [1:0] exp_src;
  } vec_t;

  vec_t vecs [12];

  task automatic applyStimulus(input logic [3:0] valids, input logic af,
                               input logic sf, input logic stall,
                               input logic fr);
    fill_valid       = valids[0];
    mrvq_valid       = valids[1];
    snp_valid        = valids[2];
    core_valid       = valids[3];
    mrvq_almost_full = af;
    snprsp_full      = sf;
    stall_bank_pipe  = stall;
    flush_req        = fr;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected st1 contents for a granted request from the given source.
  task automatic checkSt1(input string name, input logic [1:0] src);
    logic [LAW-1:0] e_addr;
    logic [LW-1:0]  e_data;
    logic [31:0]    e_word;
    logic [4:0]     e_flags;  // {writefill, is_snp, snp_inv, rw, flush}
    logic [13:0]    e_meta;   // {byteen, wsel, tag}
    e_data = '0;
    e_word = '0;
    e_meta = '0;
    case (src)
      SRC_FILL: begin
        e_addr = FILL_ADDR; e_data = FILL_DATA; e_flags = 5'b10000;
      end
      SRC_MRVQ: begin
        e_addr = MRVQ_ADDR; e_word = MRVQ_WORD; e_flags = 5'b00010;
        e_meta = {MRVQ_BEN, MRVQ_WSEL, MRVQ_TAG};
      end
      SRC_SNP: begin
        e_addr = SNP_ADDR; e_flags = 5'b01000;
      end
      default: begin
        e_addr = CORE_ADDR; e_word = CORE_WORD; e_flags = 5'b00000;
        e_meta = {CORE_BEN, CORE_WSEL, CORE_TAG};
      end
    endcase
    checkOutput({name, ".valid"}, st1_valid, 1'b1);
    checkOutput({name, ".src"}, st1_src, src);
    checkOutput({name, ".addr"}, st1_addr, e_addr);
    checkOutput({name, ".data"}, st1_data, e_data);
    checkOutput({name, ".word"}, st1_word, e_word);
    checkOutput({name, ".flags"},
                {st1_writefill, st1_is_snp, st1_snp_inv, st1_rw, st1_flush}, e_flags);
    checkOutput({name, ".meta"}, {st1_byteen, st1_wsel, st1_tag}, e_meta);
  endtask

  task automatic checkSweep(input string name, input int idx);
    checkOutput({name, ".valid"}, st1_valid, 1'b1);
    checkOutput({name, ".addr"}, st1_addr, 128'(idx));
    checkOutput({name, ".flags"},
                {st1_writefill, st1_is_snp, st1_snp_inv, st1_rw, st1_flush}, 5'b01101);
    checkOutput({name, ".src"}, st1_src, 2'd0);
  endtask

  initial begin
    vecs[0]  = '{4'b0001, 0, 0, 4'b0001, 1, SRC_FILL};
    vecs[1]  = '{4'b0010, 0, 0, 4'b0010, 1, SRC_MRVQ};
    vecs[2]  = '{4'b0100, 0, 0, 4'b0100, 1, SRC_SNP};
    vecs[3]  = '{4'b1000, 0, 0, 4'b1000, 1, SRC_CORE};
    vecs[4]  = '{4'b0100, 0, 1, 4'b0000, 0, SRC_FILL};
    vecs[5]  = '{4'b1000, 1, 0, 4'b0000, 0, SRC_FILL};
    vecs[6]  = '{4'b1001, 1, 0, 4'b0001, 1, SRC_FILL};
    vecs[7]  = '{4'b0011, 0, 0, 4'b0001, 1, SRC_FILL};
    vecs[8]  = '{4'b0110, 0, 0, 4'b0010, 1, SRC_MRVQ};
    vecs[9]  = '{4'b1100, 0, 0, 4'b0100, 1, SRC_SNP};
    vecs[10] = '{4'b1100, 0, 1, 4'b1000, 1, SRC_CORE};
    vecs[11] = '{4'b0000, 0, 0, 4'b0000, 0, SRC_FILL};

    // Reset state, then the power-on sweep with core waiting.
    reset = 1'b1;
    applyStimulus(4'b0000, 0, 0, 0, 0);
    #11;
    checkOutput("reset.st1_valid", st1_valid, 1'b0);
    checkOutput("reset.st1_addr", st1_addr, '0);
    checkOutput("reset.flush_done", flush_done, 1'b0);
    checkOutput("reset.flush_busy", flush_busy, 1'b1);
    applyStimulus(4'b1000, 0, 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < NL; i++) begin
      #1;
      checkOutput("init.rdy", rdy, 4'b0000);
      @(posedge clk); #1;
      checkSweep("init.op", i);
      checkOutput("init.flush_done", flush_done, (i == NL - 1));
    end
    #1;
    checkOutput("init.busy_after", flush_busy, 1'b0);
    checkOutput("init.core_rdy", rdy, 4'b1000);
    @(posedge clk); #1;
    checkSt1("init.core", SRC_CORE);
    checkOutput("init.done_cleared", flush_done, 1'b0);

    // Single-cycle arbitration vectors.
    for (int v = 0; v < 12; v++) begin
      applyStimulus(vecs[v].valids, vecs[v].af, vecs[v].sf, 0, 0);
      #1;
      checkOutput($sformatf("vec%0d.rdy", v), rdy, vecs[v].exp_rdy);
      @(posedge clk); #1;
      if (vecs[v].exp_vld) checkSt1($sformatf("vec%0d", v), vecs[v].exp_src);
      else checkOutput($sformatf("vec%0d.st1_valid", v), st1_valid, 1'b0);
    end

    // All four valid, each source withdraws once granted.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b1111 & ~((4'b0001 << k) - 4'b0001), 0, 0, 0, 0);
      #1;
      checkOutput($sformatf("order%0d.rdy", k), rdy, 4'b0001 << k);
      @(posedge clk); #1;
      checkSt1($sformatf("order%0d", k), 2'(k));
    end

    // Starvation: mrvq and core held valid, core promoted on the 9th cycle.
    applyStimulus(4'b1010, 0, 0, 0, 0);
    for (int c = 1; c <= SL + 1; c++) begin
      #1;
      checkOutput($sformatf("starve%0d.rdy", c), rdy, (c == SL + 1) ? 4'b1000 : 4'b0010);
      @(posedge clk); #1;
      checkSt1($sformatf("starve%0d", c), (c == SL + 1) ? SRC_CORE : SRC_MRVQ);
    end

    // Stall with core loaded: st1 holds, readies low, counter frozen.
    applyStimulus(4'b1011, 0, 0, 1, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput($sformatf("stall%0d.rdy", c), rdy, 4'b0000);
      @(posedge clk); #1;
      checkSt1($sformatf("stall%0d", c), SRC_CORE);
    end
    applyStimulus(4'b1010, 0, 0, 0, 0);
    for (int c = 1; c <= SL + 1; c++) begin
      @(posedge clk); #1;
      checkSt1($sformatf("post_stall%0d", c), (c == SL + 1) ? SRC_CORE : SRC_MRVQ);
    end

    // Flush request in RUN: the same-cycle grant proceeds, then the sweep.
    applyStimulus(4'b1000, 0, 0, 0, 1);
    #1;
    checkOutput("flush.core_rdy", rdy, 4'b1000);
    @(posedge clk); #1;
    checkSt1("flush.core", SRC_CORE);
    checkOutput("flush.busy", flush_busy, 1'b1);
    applyStimulus(4'b0000, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checkSweep("flush.op", i);
    end

    // Reset with sweep_idx at 20 drops the op and restarts at index 0.
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midreset.st1_valid", st1_valid, 1'b0);
    checkOutput("midreset.busy", flush_busy, 1'b1);
    reset = 1'b0;
    applyStimulus(4'b0001, 0, 0, 0, 1);
    for (int i = 0; i < NL; i++) begin
      checkOutput("resweep.rdy", rdy, 4'b0000);
      @(posedge clk); #1;
      checkSweep("resweep.op", i);
      checkOutput("resweep.flush_done", flush_done, (i == NL - 1));
    end

    // flush_req held during the sweep must not start a second one.
    applyStimulus(4'b1000, 0, 0, 0, 0);
    #1;
    checkOutput("nosecond.busy", flush_busy, 1'b0);
    checkOutput("nosecond.rdy", rdy, 4'b1000);
    @(posedge clk); #1;
    checkSt1("nosecond.core", SRC_CORE);
    checkOutput("nosecond.busy2", flush_busy, 1'b0);
    checkOutput("nosecond.done", flush_done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
